// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives instruction-memory addresses, collects returned bytes and
// tracks two-byte (opcode + immediate) instructions for the IF/ID register.
module instr_fetch_unit #(
    parameter int         ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0] TWO_BYTE_OP = 4'hC,
    parameter logic [7:0] HALT_OP     = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [7:0]        imem_data,
    input  logic              imem_valid,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    output logic [7:0]        ir_new,
    output logic              sf1_out,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_F1   = 2'd0,
        S_F2   = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_next;
    logic [7:0]        ir_next;
    logic              sf1_next;
    logic              fv_next;
    logic              halted_next;
    logic              accept;

    assign imem_addr = pc;
    assign imem_req  = rst & ~stall & ~flush & ~branch_taken & (state != S_HALT);
    assign accept    = imem_req & imem_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_F1;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_PC;
            ir_new      <= 8'h00;
            sf1_out     <= 1'b0;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            pc          <= pc_next;
            ir_new      <= ir_next;
            sf1_out     <= sf1_next;
            fetch_valid <= fv_next;
            halted      <= halted_next;
        end
    end

    // Priority: branch > flush > stall > halt idle > accept > memory wait.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        ir_next     = ir_new;
        sf1_next    = sf1_out;
        fv_next     = fetch_valid;
        halted_next = halted;

        if (branch_taken) begin
            pc_next     = branch_target;
            state_next  = S_F1;
            halted_next = 1'b0;
            fv_next     = 1'b0;
            sf1_next    = 1'b0;
            ir_next     = 8'h00;
        end else if (flush) begin
            fv_next  = 1'b0;
            sf1_next = 1'b0;
            ir_next  = 8'h00;
            if (state != S_HALT) begin
                state_next = S_F1;
            end
        end else if (stall) begin
            state_next = state;
        end else if (state == S_HALT) begin
            fv_next  = 1'b0;
            sf1_next = 1'b0;
        end else if (accept) begin
            ir_next = imem_data;
            fv_next = 1'b1;
            pc_next = pc + ADDR_W'(1);
            if (state == S_F2) begin
                // The immediate is plain data, never decoded as an opcode.
                sf1_next   = 1'b1;
                state_next = S_F1;
            end else begin
                sf1_next = 1'b0;
                if (imem_data[7:4] == TWO_BYTE_OP) begin
                    state_next = S_F2;
                end else if (imem_data == HALT_OP) begin
                    state_next  = S_HALT;
                    halted_next = 1'b1;
                end
            end
        end else begin
            fv_next  = 1'b0;
            sf1_next = 1'b0;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage that generates instruction-memory addresses and collects returned bytes.
- Presents `ir_new` / `sf1` to the IF/ID instruction register, which latches them every clock.
- Tracks two-byte instructions: byte 1 is the opcode, byte 2 is the immediate, flagged with `sf1_out=1`.
- Handles stall, flush, branch redirect and halt.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width.
- RESET_PC, 0, PC value loaded on reset.
- TWO_BYTE_OP, 4'hC, opcode[7:4] value marking a two-byte instruction.
- HALT_OP, 8'hFF, full opcode byte that halts fetching.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- stall  in  1  hold fetch state and outputs.
- flush  in  1  squash current/in-flight fetch.
- branch_taken  in  1  redirect PC.
- branch_target  in  ADDR_W  redirect address.
- imem_data  in  8  byte returned by instruction memory.
- imem_valid  in  1  `imem_data` valid for the current `imem_addr`.
- imem_addr  out  ADDR_W  fetch address (= registered pc).
- imem_req  out  1  fetch request.
- ir_new  out  8  byte to instruction register.
- sf1_out  out  1  1 = `ir_new` is the second byte of a two-byte instruction.
- fetch_valid  out  1  `ir_new` holds a newly fetched byte.
- pc  out  ADDR_W  current fetch PC.
- halted  out  1  fetch stopped by HALT_OP.

Behaviour:
- Reset: one clock, synchronous, active-low. On a clk edge with rst=0:
  - pc=RESET_PC, state=F1.
  - ir_new=0, sf1_out=0, fetch_valid=0, halted=0.
  - rst dominates all other inputs, including mid-instruction (state F2) and HALT.
- States:
  - F1: fetch first/only byte.
  - F2: fetch immediate byte.
  - HALT.
- Outputs ir_new, sf1_out, fetch_valid, pc, halted are registered.
- imem_addr = pc.
- imem_req (combinational) = rst & ~stall & ~flush & ~branch_taken & (state!=HALT).
- Accept condition: imem_req & imem_valid. On accept:
  - ir_new <= imem_data, fetch_valid <= 1.
  - pc <= pc+1, modulo 2^ADDR_W (wrap 8'hFF -> 8'h00).
  - Latency: a byte accepted at edge N is on ir_new after edge N.
- In F1, on accept:
  - sf1_out <= 0.
  - If imem_data[7:4]==TWO_BYTE_OP: -> F2.
  - Else if imem_data==HALT_OP: -> HALT, halted <= 1; pc still increments.
  - Else: stay F1.
- In F2, on accept:
  - sf1_out <= 1, -> F1.
  - The immediate byte is never decoded as an opcode; HALT_OP or TWO_BYTE_OP values here are plain data.
- No accept (imem_valid=0, not stalled):
  - fetch_valid <= 0, sf1_out <= 0.
  - ir_new holds; state and pc hold.
- Stall (no branch/flush): all registers hold, including fetch_valid; imem_req=0.
- Priority: rst > branch_taken > flush > stall > accept.
- branch_taken:
  - pc <= branch_target, state <= F1, halted <= 0.
  - fetch_valid <= 0, sf1_out <= 0, ir_new <= 0.
  - Overrides stall and any pending F2; a half-fetched two-byte instruction is discarded.
- flush without branch:
  - fetch_valid <= 0, sf1_out <= 0, ir_new <= 0.
  - state <= F1 unless HALT (HALT holds).
  - pc holds; an in-flight imem_valid is ignored.
- HALT:
  - imem_req=0; imem_valid ignored.
  - fetch_valid and sf1_out cleared the cycle after entry; ir_new holds the HALT byte.
  - Left only by reset or branch_taken.

Test Plan:
- Reset then one-byte ops: rst=0 for 1 edge, then imem_valid=1 returning 8'h12, 8'h34 -> imem_addr 0,1,2; ir_new 12,34; sf1_out 0,0; fetch_valid 1; pc=2.
- Two-byte: bytes C5, 7A, 01 -> sf1_out sequence 0,1,0. Then byte C0 followed by immediate FF -> immediate FF delivered with sf1_out=1, no halt.
- Stall and memory wait:
  - After an accept, stall=1 for 3 cycles -> imem_req=0; pc, ir_new, fetch_valid, sf1_out frozen.
  - imem_valid=0 for 2 cycles -> fetch_valid=0 and sf1_out=0 for those cycles; pc unchanged.
- Branch mid two-byte:
  - In F2 at pc=0x21, branch_taken=1, branch_target=0x80, stall=1 -> next edge pc=0x80, state F1, fetch_valid=0, sf1_out=0, ir_new=0.
  - Next byte 0x05 -> sf1_out=0.
- Flush alone: in F2 at pc=0x11 -> fetch_valid=0, sf1_out=0, ir_new=0, pc=0x11, next accepted byte has sf1_out=0.
- Halt, wrap and reset:
  - Start pc=0xFF, byte FF -> halted=1, pc=0x00, imem_req stays 0 for 10 cycles.
  - Flush during HALT -> still halted.
  - branch_target=0x40 -> halted=0, fetch resumes at 0x40.
  - rst=0 while in F2 -> pc=RESET_PC, state F1, all outputs 0.
